mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Load/store initiator between the core's memory stage and the data-port side of the byte-lane memory interface.
- Accepts one core request at a time and range-checks it.
- Drives mem_en, mem_addr, mem_din, mem_wen and storecntrl_b toward the memory.
- Waits the synchronous read latency, then returns sign- or zero-extended load data, or a store acknowledge, on a one-cycle response strobe.

Parameters:
- MEM_WORDS, 2048: words per bank; the valid byte range is 0 .. 4*MEM_WORDS-1.
- MEM_LAT, 1: cycles from the mem_en cycle until mem_dout is valid (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request strobe
- req_ready  out  1  LSU can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address; any alignment is legal
- req_wdata  in  32  store data, LSB-justified
- resp_valid  out  1  one-cycle response strobe
- resp_err  out  1  qualifies resp_valid: access fault
- resp_rdata  out  32  extended load data; 0 for stores and faults
- mem_en  out  1  memory data-port enable
- mem_addr  out  32  byte address to memory
- mem_din  out  32  store data, LSB-justified (the memory rotates lanes)
- mem_wen  out  4  per-physical-bank write enable
- storecntrl_b  out  3  001 = byte, 010 = halfword, 100 = word, 000 = load
- mem_dout  in  32  memory read data, already lane-aligned to the address

Behaviour:
- Reset:
  - State goes to IDLE; pending request is discarded; no response is produced.
  - req_ready=0 during the rst cycle and 1 from the first cycle after.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_en=0, mem_wen=0, storecntrl_b=0, mem_addr=0, mem_din=0.
- All outputs are registered except req_ready, which is decoded from the state (1 only in IDLE).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Handshake occurs on req_valid & req_ready; the request fields are captured.
  - Fault condition: req_size=11, or req_addr + nbytes - 1 > 4*MEM_WORDS-1, where nbytes = 1, 2 or 4 and the sum is computed at 33 bits, so there is no wrap.
  - Fault: go to RESP with resp_err=1 and no memory access.
  - Otherwise: go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_en=1, mem_addr=captured address.
  - Store:
    - mem_din=req_wdata.
    - storecntrl_b is the size code.
    - mem_wen = base mask (0001 / 0011 / 1111) rotated left by addr[1:0]; e.g. a halfword at offset 3 gives 1001.
    - Next state is RESP.
  - Load: mem_wen=0, storecntrl_b=000. Next state is WAIT, with a counter loaded to MEM_LAT-1.
  - Outside ISSUE: mem_en, mem_wen and storecntrl_b are 0. mem_addr and mem_din hold their last values.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, sample mem_dout and go to RESP.
- Load extension:
  - Byte: mem_dout[7:0], with bit 7 replicated unless unsigned.
  - Halfword: mem_dout[15:0], with bit 15 replicated unless unsigned.
  - Word: passed through unchanged; req_unsigned is ignored.
- RESP (exactly one cycle): resp_valid=1. The next state is always IDLE.
- Latency for MEM_LAT=1, request accepted in cycle T:
  - Load: mem_en in T+1, mem_dout sampled in T+2, resp_valid in T+3.
  - Store: mem_en in T+1, resp_valid in T+2.
  - Fault: resp_valid in T+1.
- No new request is accepted until the cycle after RESP, so only one request is ever outstanding.
- Wrap within the array (e.g. a word at offset 1 of the last-but-one word) is legal and is handled by the memory. The LSU checks only the upper bound.
- req_* inputs are ignored outside the accept cycle; changing them mid-operation has no effect.
- rst asserted in any state overrides everything on that edge.

Test Plan:
- Store word 0xDEADBEEF to 0x100, then load word from 0x100. Store: ISSUE shows mem_wen=1111, storecntrl_b=100, resp_valid at T+2 with rdata=0. Load: resp_rdata=0xDEADBEEF at T+3.
- Store byte 0x80 to 0x203, then lb and lbu from 0x203. Store: mem_wen=1000, storecntrl_b=001. lb returns 0xFFFFFF80; lbu returns 0x00000080.
- Store halfword 0x8001 to 0x107 (offset 3). Store: mem_wen=1001, storecntrl_b=010. lh from 0x107 returns 0xFFFF8001; lhu returns 0x00008001.
- Word load at 0x1FFD with MEM_WORDS=2048:
  - Expect resp_valid with resp_err=1 at T+1 and no mem_en pulse.
  - Word at 0x1FFC succeeds.
  - req_size=11 faults.
- Back-to-back req_valid held high:
  - req_ready is low from T+1 until the cycle after RESP.
  - The second request is accepted then.
  - Exactly one resp_valid per accepted request.
- Reset mid-operation:
  - Assert rst during WAIT: no resp_valid, all outputs 0, req_ready=1 the cycle after rst deasserts.
  - With MEM_LAT=3, the load response arrives at T+5.

Source files
------------

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu
//  Brief    : Single-outstanding load/store initiator. Range-checks a core
//             request, drives one memory data-port access and returns a
//             sign/zero-extended load result or a store acknowledge.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int MEM_WORDS = 2048,
    parameter int MEM_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_wen,
    output logic [2:0]  storecntrl_b,
    input  logic [31:0] mem_dout
);

    // Width of the read-latency counter; at least one bit even for MEM_LAT=1.
    localparam int                 c_CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAT_M1    = c_CNT_W'(MEM_LAT - 1);
    // Highest legal byte address, held at 33 bits so the end-address sum never wraps.
    localparam logic [32:0]        c_LAST_BYTE = 33'(4 * MEM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    // Request fields that must survive past the accept cycle.
    logic                 r_we;
    logic [1:0]           r_size;
    logic                 r_unsigned;

    // Registered outputs and their next values.
    logic                 r_resp_valid, w_resp_valid_nxt;
    logic                 r_resp_err,   w_resp_err_nxt;
    logic [31:0]          r_resp_rdata, w_resp_rdata_nxt;
    logic                 r_mem_en,     w_mem_en_nxt;
    logic [31:0]          r_mem_addr,   w_mem_addr_nxt;
    logic [31:0]          r_mem_din,    w_mem_din_nxt;
    logic [3:0]           r_mem_wen,    w_mem_wen_nxt;
    logic [2:0]           r_storecntrl, w_storecntrl_nxt;

    // Request decode.
    logic [1:0]           w_nbytes_m1;
    logic [32:0]          w_end_addr;
    logic                 w_fault;
    logic [2:0]           w_size_code;
    logic [3:0]           w_base_mask;
    logic [3:0]           w_wen_mask;
    logic [31:0]          w_load_ext;

    assign req_ready    = (r_state == S_IDLE) && !rst;
    assign resp_valid   = r_resp_valid;
    assign resp_err     = r_resp_err;
    assign resp_rdata   = r_resp_rdata;
    assign mem_en       = r_mem_en;
    assign mem_addr     = r_mem_addr;
    assign mem_din      = r_mem_din;
    assign mem_wen      = r_mem_wen;
    assign storecntrl_b = r_storecntrl;

    // Decode size into byte count, store size code and unrotated lane mask.
    always_comb begin
        w_nbytes_m1 = 2'd3;
        w_size_code = 3'b000;
        w_base_mask = 4'b0000;
        case (req_size)
            2'b00: begin w_nbytes_m1 = 2'd0; w_size_code = 3'b001; w_base_mask = 4'b0001; end
            2'b01: begin w_nbytes_m1 = 2'd1; w_size_code = 3'b010; w_base_mask = 4'b0011; end
            2'b10: begin w_nbytes_m1 = 2'd3; w_size_code = 3'b100; w_base_mask = 4'b1111; end
            default: begin w_nbytes_m1 = 2'd3; w_size_code = 3'b000; w_base_mask = 4'b0000; end
        endcase
    end

    assign w_end_addr = {1'b0, req_addr} + {31'd0, w_nbytes_m1};
    assign w_fault    = (req_size == 2'b11) || (w_end_addr > c_LAST_BYTE);

    // Rotate the lane mask left by the byte offset; lanes past bank 3 wrap to bank 0.
    always_comb begin
        w_wen_mask = w_base_mask;
        case (req_addr[1:0])
            2'd0:    w_wen_mask = w_base_mask;
            2'd1:    w_wen_mask = {w_base_mask[2:0], w_base_mask[3]};
            2'd2:    w_wen_mask = {w_base_mask[1:0], w_base_mask[3:2]};
            default: w_wen_mask = {w_base_mask[0],   w_base_mask[3:1]};
        endcase
    end

    // Sign- or zero-extend the lane-aligned read data according to the captured size.
    always_comb begin
        w_load_ext = mem_dout;
        case (r_size)
            2'b00:   w_load_ext = {{24{~r_unsigned & mem_dout[7]}},  mem_dout[7:0]};
            2'b01:   w_load_ext = {{16{~r_unsigned & mem_dout[15]}}, mem_dout[15:0]};
            default: w_load_ext = mem_dout;
        endcase
    end

    // Next-state and next-output decode; every output defaults to its idle value.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = 32'd0;
        w_mem_en_nxt     = 1'b0;
        w_mem_wen_nxt    = 4'b0000;
        w_storecntrl_nxt = 3'b000;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_din_nxt    = r_mem_din;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_fault) begin
                        w_state_nxt      = S_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt    = S_ISSUE;
                        w_mem_en_nxt   = 1'b1;
                        w_mem_addr_nxt = req_addr;
                        if (req_we) begin
                            w_mem_din_nxt    = req_wdata;
                            w_mem_wen_nxt    = w_wen_mask;
                            w_storecntrl_nxt = w_size_code;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_LAT_M1;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = w_load_ext;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_din    <= 32'd0;
            r_mem_wen    <= 4'b0000;
            r_storecntrl <= 3'b000;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_din    <= w_mem_din_nxt;
            r_mem_wen    <= w_mem_wen_nxt;
            r_storecntrl <= w_storecntrl_nxt;
        end
    end

    // Capture the request fields needed after the accept cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
        end
    end

endmodule
`default_nettype wire
